// File: rtl/usr_pkg.sv
// usr_pkg: mode encodings and lane-count helper for the universal shift register.
package usr_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_SHR   = 3'd1,
    MODE_SHL   = 3'd2,
    MODE_LOAD  = 3'd3,
    MODE_ROTR  = 3'd4,
    MODE_ROTL  = 3'd5,
    MODE_CLEAR = 3'd6,
    MODE_RSVD  = 3'd7
  } usr_mode_t;

  function automatic int lane_count(input int width, input int lane_w);
    return width / lane_w;
  endfunction
endpackage

// File: rtl/usr_fill_counter.sv
// usr_fill_counter: saturating count of lanes shifted in, with a one-cycle word_done pulse.
module usr_fill_counter #(
  parameter int LANES = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         inc,
  input  logic                         clr,
  output logic [$clog2(LANES+1)-1:0]   cnt,
  output logic                         done
);
  localparam int CW = $clog2(LANES + 1);
  localparam logic [CW-1:0] MAX = CW'(LANES);
  if (LANES < 1) begin : g_bad_lanes
    $error("usr_fill_counter: LANES must be at least 1");
  end
  // done fires only on the step into MAX, so a saturated counter never re-pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= inc && !clr && cnt == MAX - 1'b1;
      cnt  <= clr ? '0 : (inc && cnt != MAX) ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: rtl/universal_shift_reg.sv
// universal_shift_reg: multi-lane shift/load/clear register; rotate modes built only with USR_ROTATE_EN.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANE_W = 1
) (
  input  logic                                            clk,
  input  logic                                            reset_n,
  input  logic                                            en,
  input  logic [2:0]                                      mode,
  input  logic [LANE_W-1:0]                               serial_in,
  input  logic [WIDTH-1:0]                                par_in,
  output logic [LANE_W-1:0]                               serial_out,
  output logic [WIDTH-1:0]                                par_out,
  output logic                                            word_done,
  output logic [$clog2(lane_count(WIDTH, LANE_W)+1)-1:0]  fill_cnt
);
  localparam int LANES = lane_count(WIDTH, LANE_W);
  if (WIDTH < 2 || WIDTH > 64 || LANE_W < 1 || WIDTH % LANE_W != 0) begin : g_bad_param
    $error("universal_shift_reg: WIDTH must be 2..64 and a multiple of LANE_W");
  end
  logic [WIDTH-1:0] data, data_nxt, shr, shl;
  logic dir, dir_nxt;
  usr_mode_t op;
  assign op  = en ? usr_mode_t'(mode) : MODE_HOLD;
  // shifts written as whole-word shifts so WIDTH == LANE_W needs no special slicing
  assign shr = (data >> LANE_W) | (WIDTH'(serial_in) << (WIDTH - LANE_W));
  assign shl = (data << LANE_W) | WIDTH'(serial_in);
`ifdef USR_ROTATE_EN
  logic [WIDTH-1:0] rotr, rotl;
  assign rotr = (data >> LANE_W) | (data << (WIDTH - LANE_W));
  assign rotl = (data << LANE_W) | (data >> (WIDTH - LANE_W));
  always_comb begin
    data_nxt = op == MODE_SHR   ? shr    :
               op == MODE_SHL   ? shl    :
               op == MODE_LOAD  ? par_in :
               op == MODE_ROTR  ? rotr   :
               op == MODE_ROTL  ? rotl   :
               op == MODE_CLEAR ? '0     : data;
    dir_nxt  = (op == MODE_SHR || op == MODE_ROTR) ? 1'b1 :
               (op == MODE_SHL || op == MODE_ROTL) ? 1'b0 : dir;
  end
`else
  always_comb begin
    data_nxt = op == MODE_SHR   ? shr    :
               op == MODE_SHL   ? shl    :
               op == MODE_LOAD  ? par_in :
               op == MODE_CLEAR ? '0     : data;
    dir_nxt  = op == MODE_SHR ? 1'b1 : op == MODE_SHL ? 1'b0 : dir;
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data <= '0;
      dir  <= 1'b0;
    end else begin
      data <= data_nxt;
      dir  <= dir_nxt;
    end
  end
  // dir set means the last shift moved toward the LSB, so the low lane is the one leaving
  assign serial_out = dir ? data[LANE_W-1:0] : data[WIDTH-1 -: LANE_W];
  assign par_out    = data;
  usr_fill_counter #(.LANES(LANES)) u_fill (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (op == MODE_SHR || op == MODE_SHL),
    .clr     (op == MODE_LOAD || op == MODE_CLEAR),
    .cnt     (fill_cnt),
    .done    (word_done)
  );
endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the register width in bits; legal values are 2..64.
REQ-002 SHALL provide parameter LANE_W, default 1, the serial lane width in bits; WIDTH SHALL be an integer multiple of LANE_W.
REQ-003 SHALL provide port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL provide port en, input, 1 bit, the clock enable; when low, all state holds.
REQ-006 SHALL provide port mode, input, 3 bits, the operation select (encodings in REQ-012).
REQ-007 SHALL provide port serial_in, input, LANE_W bits, the serial input lane.
REQ-008 SHALL provide port par_in, input, WIDTH bits, the parallel load data.
REQ-009 SHALL provide port serial_out, output, LANE_W bits, the serial output lane.
REQ-010 SHALL provide port par_out, output, WIDTH bits, the register contents.
REQ-011 SHALL provide port word_done, output, 1 bit, a one-cycle pulse when a full word has been shifted in.
REQ-011a SHALL provide port fill_cnt, output, clog2(WIDTH/LANE_W+1) bits, the number of lanes shifted in since the last load or clear.

Function
REQ-012 The mode encodings SHALL be:
- 0 HOLD
- 1 SHR: shift toward LSB; serial_in enters the top LANE_W bits.
- 2 SHL: shift toward MSB; serial_in enters the bottom LANE_W bits.
- 3 LOAD: register takes par_in.
- 4 ROTR
- 5 ROTL
- 6 CLEAR: register becomes zero.
- 7: reserved; SHALL behave as HOLD.
REQ-013 serial_out SHALL be registered-state-driven, with 0-cycle combinational latency from the register:
- the low LANE_W bits when the last shift mode was SHR or ROTR;
- the high LANE_W bits otherwise.
REQ-013a The direction flag for serial_out SHALL be held in a 1-bit register that updates on SHR/SHL/ROTR/ROTL only.
REQ-014 par_out SHALL equal the register, with no added latency.
REQ-015 Data shifted in at edge N SHALL appear on par_out after edge N; a value entered serially SHALL reach serial_out after WIDTH/LANE_W shifts.
REQ-016 fill_cnt SHALL increment by 1 on each SHR/SHL with en high, saturating at WIDTH/LANE_W.
REQ-016a fill_cnt SHALL reset to 0 on LOAD or CLEAR.
REQ-016b fill_cnt SHALL be unchanged by HOLD, ROTR, ROTL and reserved.
REQ-017 word_done SHALL pulse high for exactly one cycle on the edge where fill_cnt transitions from WIDTH/LANE_W-1 to WIDTH/LANE_W.
REQ-017a word_done SHALL NOT re-pulse while fill_cnt is saturated.
REQ-018 After saturation, further shifts SHALL continue to move data; fill_cnt SHALL stay at its maximum.
REQ-019 With en low, mode and serial_in SHALL be ignored; word_done SHALL be low.
REQ-020 When WIDTH equals LANE_W, a single shift SHALL replace the whole register and pulse word_done.

Reset
REQ-021 While reset_n is low at a rising edge, the following SHALL become 0: register, par_out, serial_out, fill_cnt, word_done and the direction flag (SHL).
REQ-022 Reset SHALL take priority over en and mode; a shift in progress SHALL be discarded with no word_done.
REQ-023 The first operation SHALL take effect on the first edge with reset_n high.

Configuration
REQ-024 Macro USR_ROTATE_EN SHALL control the rotate modes.
- Defined: ROTR and ROTL SHALL rotate by LANE_W bits, with bits leaving one end entering the other.
- Undefined: modes 4 and 5 SHALL behave as HOLD, and the rotate datapath SHALL NOT be synthesised.

Structure
REQ-025 Package usr_pkg SHALL hold:
- the mode enumeration typedef usr_mode_t with the REQ-012 encodings;
- a function returning WIDTH/LANE_W lane count.
REQ-026 The fill counter and word_done pulse logic SHALL be a sub-module named usr_fill_counter.
REQ-026a usr_fill_counter SHALL be parametrised by lane count, with inputs inc and clr.
REQ-027 Illegal parameter combinations SHALL produce an elaboration-time error.

Verification
REQ-028 Reset: reset_n=0 for 2 cycles with mode=LOAD, par_in=8'hFF -> par_out=8'h00, fill_cnt=0, word_done=0.
REQ-029 SIPO: WIDTH=8, LANE_W=1, SHL with serial_in 1,0,1,1,0,0,1,0 -> par_out=8'hB2 and word_done high on the 8th edge only.
REQ-030 PISO: LOAD 8'hA5, then 8 SHR cycles -> serial_out sequence 1,0,1,0,0,1,0,1 and fill_cnt=0 immediately after LOAD.
REQ-031 Multi-lane: WIDTH=16, LANE_W=4, 4 SHL of 4'h1,4'h2,4'h3,4'h4 -> par_out=16'h1234 and word_done on the 4th shift.
REQ-032 Rotate: with USR_ROTATE_EN, LOAD 8'h81 then ROTL -> 8'h03; without the macro -> 8'h81 held.
REQ-033 Mid-operation reset and en: reset_n low after 3 of 8 shifts -> fill_cnt=0 and no word_done; en low for 2 cycles -> state and fill_cnt unchanged.
